// File: rtl/eq_stream_checker.sv
// rtl/eq_stream_checker.sv - latency-insensitive lockstep stream equivalence checker
//
// Purpose:
//   Steps two designs under check (ILA-generated RTL and HLS RTL) in lockstep,
//   buffers each side's accepted output beats in a per-side FIFO, pops both
//   heads together and compares them in order. Produces a sticky pass/fail
//   verdict with an error code. Each side is frozen before its FIFO can fill.
//
// Optional feature macro: EQ_CHK_TIMEOUT_EN
//   Builds an idle-cycle watchdog that fails with err_code=4 after TIMEOUT
//   RUN/DRAIN cycles with no push and no pop.
//
// Ports:
//   clk            in   clock for checker and both steppers
//   rst            in   asynchronous active-high reset
//   ila_complete   in   ILA side finished its instruction
//   hls_complete   in   HLS side finished its instruction
//   ila_step       out  registered step enable to the ILA side
//   hls_step       out  registered step enable to the HLS side
//   out_ready      in   shared sink ready seen by both sides
//   ila_out_valid  in   ILA output beat valid
//   ila_out_data   in   ILA output beat data [DATA_W]
//   hls_out_valid  in   HLS output beat valid
//   hls_out_data   in   HLS output beat data [DATA_W]
//   match_cnt      out  saturating count of equal beat pairs [CNT_W]
//   mismatch       out  sticky fail flag
//   err_code       out  0 none, 1 data, 2 overflow, 3 length, 4 timeout
//   done           out  sticky verdict-reached flag

module eq_stream_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

module eq_stream_checker #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ila_complete,
    input  logic              hls_complete,
    output logic              ila_step,
    output logic              hls_step,
    input  logic              out_ready,
    input  logic              ila_out_valid,
    input  logic [DATA_W-1:0] ila_out_data,
    input  logic              hls_out_valid,
    input  logic [DATA_W-1:0] hls_out_data,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              mismatch,
    output logic [2:0]        err_code,
    output logic              done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    // One slot of headroom: the step register lags the push by a cycle.
    localparam logic [CW-1:0] STEP_LIM = CW'(DEPTH - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("eq_stream_checker: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t state, state_nx;
    logic [2:0] err_nx;

    logic [DATA_W-1:0] ila_head, hls_head;
    logic [CW-1:0]     ila_cnt, hls_cnt;
    logic [CW-1:0]     ila_cnt_nx, hls_cnt_nx;
    logic              active, active_nx;
    logic              ila_push, hls_push, pop;
    logic              ila_empty, hls_empty;
    logic              ila_ovf, hls_ovf;
    logic              data_err, ovf_err, len_err, timeout_hit;

    assign active    = (state == S_RUN) || (state == S_DRAIN);
    assign active_nx = (state_nx == S_RUN) || (state_nx == S_DRAIN);

    assign ila_push  = active & ila_out_valid & out_ready & ila_step;
    assign hls_push  = active & hls_out_valid & out_ready & hls_step;
    assign ila_empty = (ila_cnt == '0);
    assign hls_empty = (hls_cnt == '0);
    assign pop       = active & ~ila_empty & ~hls_empty;

    // A simultaneous pop frees a slot, so only a push into a full FIFO
    // without a pop is an overflow.
    assign ila_ovf  = ila_push & (ila_cnt == FULL_CNT) & ~pop;
    assign hls_ovf  = hls_push & (hls_cnt == FULL_CNT) & ~pop;
    assign ovf_err  = ila_ovf | hls_ovf;
    assign data_err = pop & (ila_head != hls_head);
    assign len_err  = (state == S_DRAIN) & (ila_empty != hls_empty);

    assign ila_cnt_nx = ila_cnt + {{AW{1'b0}}, ila_push} - {{AW{1'b0}}, pop};
    assign hls_cnt_nx = hls_cnt + {{AW{1'b0}}, hls_push} - {{AW{1'b0}}, pop};

    eq_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ila_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ila_push & ~ila_ovf),
        .pop   (pop),
        .wdata (ila_out_data),
        .rdata (ila_head),
        .count (ila_cnt)
    );

    eq_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_hls_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hls_push & ~hls_ovf),
        .pop   (pop),
        .wdata (hls_out_data),
        .rdata (hls_head),
        .count (hls_cnt)
    );

`ifdef EQ_CHK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;
    logic          idle;

    assign idle        = active & ~ila_push & ~hls_push & ~pop;
    assign timeout_hit = idle & (idle_cnt == IW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (idle) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        err_nx   = err_code;
        case (state)
            S_IDLE: state_nx = S_RUN;
            S_RUN, S_DRAIN: begin
                if (data_err) begin
                    state_nx = S_FAIL;
                    err_nx   = 3'd1;
                end else if (ovf_err) begin
                    state_nx = S_FAIL;
                    err_nx   = 3'd2;
                end else if (len_err) begin
                    state_nx = S_FAIL;
                    err_nx   = 3'd3;
                end else if (timeout_hit) begin
                    state_nx = S_FAIL;
                    err_nx   = 3'd4;
                end else if (state == S_DRAIN && ila_empty && hls_empty) begin
                    state_nx = S_PASS;
                end else if (state == S_RUN && ila_complete && hls_complete) begin
                    state_nx = S_DRAIN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_code  <= 3'd0;
            match_cnt <= '0;
            ila_step  <= 1'b0;
            hls_step  <= 1'b0;
        end else begin
            err_code <= err_nx;
            if (pop && (ila_head == hls_head) && !(&match_cnt)) begin
                match_cnt <= match_cnt + 1'b1;
            end
            // Gating on the next state as well keeps the steps low from the
            // first PASS/FAIL cycle and through the IDLE->RUN edge.
            ila_step <= active & active_nx & ~ila_complete & (ila_cnt_nx < STEP_LIM);
            hls_step <= active & active_nx & ~hls_complete & (hls_cnt_nx < STEP_LIM);
        end
    end

    assign done     = (state == S_PASS) || (state == S_FAIL);
    assign mismatch = (state == S_FAIL);
endmodule

// File: tb/tb_eq_stream_checker.sv
// tb/tb_eq_stream_checker.sv - directed self-checking bench for eq_stream_checker
module tb_eq_stream_checker;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ila_complete = 1'b0;
    logic              hls_complete = 1'b0;
    logic              ila_step, hls_step;
    logic              out_ready = 1'b1;
    logic              ila_out_valid = 1'b0;
    logic [DATA_W-1:0] ila_out_data = '0;
    logic              hls_out_valid = 1'b0;
    logic [DATA_W-1:0] hls_out_data = '0;
    logic [CNT_W-1:0]  match_cnt;
    logic              mismatch;
    logic [2:0]        err_code;
    logic              done;

    eq_stream_checker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .ila_complete(ila_complete), .hls_complete(hls_complete),
        .ila_step(ila_step), .hls_step(hls_step),
        .out_ready(out_ready),
        .ila_out_valid(ila_out_valid), .ila_out_data(ila_out_data),
        .hls_out_valid(hls_out_valid), .hls_out_data(hls_out_data),
        .match_cnt(match_cnt), .mismatch(mismatch),
        .err_code(err_code), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cyc = -1;
    always @(negedge clk) if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [15:0] mc;
        logic [2:0]  err;
        logic        dn;
        logic        mis;
    } verdict_t;
    verdict_t sb[$];

    logic [7:0] ila_src[$];
    logic [7:0] hls_src[$];
    int   last_acc_cyc;
    int   ila_acc_at_hls;
    logic ila_step_at_hls;
    int   rel_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic expect_verdict(input int mc, input int err, input bit dn, input bit mis);
        verdict_t v;
        v.mc  = 16'(mc);
        v.err = 3'(err);
        v.dn  = dn;
        v.mis = mis;
        sb.push_back(v);
    endtask

    task automatic check_verdict(input string tag);
        verdict_t v;
        check({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            v = sb.pop_front();
            check({tag, ".match_cnt"}, 32'(match_cnt), 32'(v.mc));
            check({tag, ".err_code"},  32'(err_code),  32'(v.err));
            check({tag, ".done"},      32'(done),      32'(v.dn));
            check({tag, ".mismatch"},  32'(mismatch),  32'(v.mis));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ila_out_valid = 1'b0; hls_out_valid = 1'b0;
        ila_complete = 1'b0;  hls_complete = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rel_cyc  = cyc;
        done_cyc = -1;
    endtask

    task automatic drive(input int hls_delay, input bit bp, input int budget);
        int ii = 0;
        int hi = 0;
        bit ia, ha;
        bit seen_hls = 1'b0;
        ila_acc_at_hls  = -1;
        ila_step_at_hls = 1'bx;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (ii >= ila_src.size() && hi >= hls_src.size()) break;
            out_ready     = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            ila_out_valid = (ii < ila_src.size());
            ila_out_data  = ila_out_valid ? ila_src[ii] : 8'h00;
            hls_out_valid = (c >= hls_delay) && (hi < hls_src.size());
            hls_out_data  = hls_out_valid ? hls_src[hi] : 8'h00;
            if (hls_out_valid && !seen_hls) begin
                seen_hls        = 1'b1;
                ila_acc_at_hls  = ii;
                ila_step_at_hls = ila_step;
            end
            ia = ila_out_valid & out_ready & ila_step;
            ha = hls_out_valid & out_ready & hls_step;
            if (ia || ha) last_acc_cyc = cyc + 1;
            @(posedge clk);
            if (ia) ii++;
            if (ha) hi++;
        end
        #1;
        ila_out_valid = 1'b0;
        hls_out_valid = 1'b0;
        out_ready     = 1'b1;
    endtask

    task automatic complete_both();
        @(negedge clk);
        ila_complete = 1'b1;
        hls_complete = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && done_cyc < 0; c++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        check("rst.ila_step",  32'(ila_step),  32'd0);
        check("rst.hls_step",  32'(hls_step),  32'd0);
        check("rst.match_cnt", 32'(match_cnt), 32'd0);
        check("rst.mismatch",  32'(mismatch),  32'd0);
        check("rst.err_code",  32'(err_code),  32'd0);
        check("rst.done",      32'(done),      32'd0);
        rst = 1'b0;
        done_cyc = -1;
        @(negedge clk);
        check("first_edge.ila_step", 32'(ila_step), 32'd0);
        @(negedge clk);
        check("second_edge.ila_step", 32'(ila_step), 32'd1);
        check("second_edge.hls_step", 32'(hls_step), 32'd1);

        // Identical streams, HLS delayed, random backpressure
        expect_verdict(3, 0, 1'b1, 1'b0);
        ila_src = '{8'h11, 8'h22, 8'h33};
        hls_src = '{8'h11, 8'h22, 8'h33};
        drive(2, 1'b1, 200);
        complete_both();
        wait_done(50);
        check_verdict("equal");

        // Data mismatch on the second pair
        do_reset();
        expect_verdict(1, 1, 1'b1, 1'b1);
        ila_src = '{8'h11, 8'h22};
        hls_src = '{8'h11, 8'h23};
        drive(0, 1'b0, 100);
        wait_done(50);
        check("data.fail_latency", 32'(done_cyc), 32'(last_acc_cyc + 1));
        check_verdict("data");

        // HLS silent: ILA frozen after DEPTH-1 beats, then catches up
        do_reset();
        expect_verdict(5, 0, 1'b1, 1'b0);
        ila_src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        hls_src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        drive(12, 1'b0, 200);
        check("freeze.ila_beats", 32'(ila_acc_at_hls), 32'd3);
        check("freeze.ila_step",  32'(ila_step_at_hls), 32'd0);
        complete_both();
        wait_done(50);
        check_verdict("freeze");

        // Length mismatch found in DRAIN
        do_reset();
        expect_verdict(2, 3, 1'b1, 1'b1);
        ila_src = '{8'h01, 8'h02, 8'h03};
        hls_src = '{8'h01, 8'h02};
        drive(0, 1'b0, 100);
        complete_both();
        wait_done(50);
        check_verdict("length");

        // Asynchronous reset mid-RUN with two beats buffered
        do_reset();
        ila_src = '{8'h55, 8'h66};
        hls_src = '{};
        drive(0, 1'b0, 50);
        check("areset.pre_ila_step", 32'(ila_step), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("areset.ila_step",  32'(ila_step),  32'd0);
        check("areset.hls_step",  32'(hls_step),  32'd0);
        check("areset.match_cnt", 32'(match_cnt), 32'd0);
        check("areset.mismatch",  32'(mismatch),  32'd0);
        check("areset.err_code",  32'(err_code),  32'd0);
        check("areset.done",      32'(done),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cyc = -1;
        @(negedge clk);
        check("areset.edge1_step", 32'(ila_step), 32'd0);
        @(negedge clk);
        check("areset.edge2_step", 32'({ila_step, hls_step}), 32'd3);
        expect_verdict(1, 0, 1'b1, 1'b0);
        ila_src = '{8'h77};
        hls_src = '{8'h77};
        drive(0, 1'b0, 50);
        complete_both();
        wait_done(50);
        check_verdict("after_reset");

        // Idle watchdog
        do_reset();
`ifdef EQ_CHK_TIMEOUT_EN
        expect_verdict(0, 4, 1'b1, 1'b1);
        wait_done(40);
        check("timeout.latency", 32'(done_cyc - rel_cyc), 32'd9);
        check_verdict("timeout");
`else
        repeat (40) @(negedge clk);
        check("no_timeout.done",     32'(done),     32'd0);
        check("no_timeout.err_code", 32'(err_code), 32'd0);
        check("no_timeout.ila_step", 32'(ila_step), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
